ras_stack: RTL and testbench



---
 rtl/ras_stack.sv | 129 ++++++++++++
 tb/tb_ras_stack.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// Return address stack for the fetch stage: circular stack of return targets
// with checkpoint/restore of pointer state for mispredict recovery.
module ras_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  input  logic [1:0]         ras_ctrl_i,
  input  logic [63:0]        ras_data_i,
  input  logic               recover_i,
  input  logic [PTR_W-1:0]   recover_ptr_i,
  input  logic [PTR_W:0]     recover_cnt_i,
  input  logic [63:0]        recover_data_i,
  output logic [63:0]        ras_top_o,
  output logic               ras_empty_o,
  output logic [PTR_W-1:0]   tos_ptr_o,
  output logic [PTR_W:0]     count_o,
  output logic               overflow_o
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_POPPUSH = 2'b11
  } ras_op_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;

  logic              we;
  logic [PTR_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] ret_addr;
  ras_op_e           op;

  assign ret_addr = ras_data_i + DATA_W'(4);
  assign op       = ras_op_e'(ras_ctrl_i);

  // Next-state for pointer, occupancy and the single memory write port.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    we      = 1'b0;
    wr_idx  = tos_q;
    wr_data = ret_addr;

    if (recover_i) begin
      tos_d   = recover_ptr_i;
      cnt_d   = (recover_cnt_i > CNT_FULL) ? CNT_FULL : recover_cnt_i;
      we      = 1'b1;
      wr_idx  = recover_ptr_i;
      wr_data = recover_data_i;
    end else if (valid_i) begin
      unique case (op)
        OP_PUSH: begin
          tos_d  = tos_q + PTR_W'(1);
          we     = 1'b1;
          wr_idx = tos_q + PTR_W'(1);
          if (cnt_q == CNT_FULL) ovf_d = 1'b1;
          else                   cnt_d = cnt_q + CNT_W'(1);
        end
        OP_POP: begin
          if (cnt_q != '0) begin
            tos_d = tos_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        OP_POPPUSH: begin
          we = 1'b1;
          if (cnt_q != '0) begin
            wr_idx = tos_q;
          end else begin
            // Empty stack: a coroutine return degenerates to a plain call.
            tos_d  = tos_q + PTR_W'(1);
            wr_idx = tos_q + PTR_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Predicted top is registered from next state so outputs carry no input path.
  always_comb begin
    empty_d = (cnt_d == '0);
    if (empty_d)                     top_d = '0;
    else if (we && wr_idx == tos_d)  top_d = wr_data;
    else                             top_d = mem_q[tos_d];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tos_q   <= '0;
      cnt_q   <= '0;
      top_q   <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      tos_q   <= tos_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      if (we) mem_q[wr_idx] <= wr_data;
    end
  end

  assign ras_top_o   = top_q;
  assign ras_empty_o = empty_q;
  assign tos_ptr_o   = tos_q;
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: directed stimulus pushes hand-computed
// expectations; a monitor pops and compares one entry per clock.
module tb_ras_stack;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [1:0]  ctrl;
  logic [63:0] data;
  logic        rec;
  logic [2:0]  rec_ptr;
  logic [3:0]  rec_cnt;
  logic [63:0] rec_data;
  logic [63:0] top;
  logic        empty;
  logic [2:0]  ptr;
  logic [3:0]  cnt;
  logic        ovf;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [63:0] top;
    logic [2:0]  ptr;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  ras_stack #(.DEPTH(8), .PTR_W(3)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid),
    .ras_ctrl_i    (ctrl),
    .ras_data_i    (data),
    .recover_i     (rec),
    .recover_ptr_i (rec_ptr),
    .recover_cnt_i (rec_cnt),
    .recover_data_i(rec_data),
    .ras_top_o     (top),
    .ras_empty_o   (empty),
    .tos_ptr_o     (ptr),
    .count_o       (cnt),
    .overflow_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the state produced by each clock edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (top !== e.top || ptr !== e.ptr || cnt !== e.cnt || ovf !== e.ovf ||
          empty !== (e.cnt == 4'd0)) begin
        miscompares++;
        $display("FAIL %s: got top=%h ptr=%0d cnt=%0d ovf=%b empty=%b, want top=%h ptr=%0d cnt=%0d ovf=%b empty=%b",
                 e.name, top, ptr, cnt, ovf, empty, e.top, e.ptr, e.cnt, e.ovf, (e.cnt == 4'd0));
      end
    end
  end

  task automatic drive(input string name, input logic r, input logic v, input logic [1:0] c,
                       input logic [63:0] d, input logic rc, input logic [2:0] rp,
                       input logic [3:0] rn, input logic [63:0] rd,
                       input logic [63:0] etop, input logic [2:0] eptr,
                       input logic [3:0] ecnt, input logic eovf);
    exp_t e;
    @(negedge clk);
    rst_n = r; valid = v; ctrl = c; data = d;
    rec = rc; rec_ptr = rp; rec_cnt = rn; rec_data = rd;
    e.name = name; e.top = etop; e.ptr = eptr; e.cnt = ecnt; e.ovf = eovf;
    sb.push_back(e);
  endtask

  task automatic op(input string name, input logic v, input logic [1:0] c, input logic [63:0] d,
                    input logic [63:0] etop, input logic [2:0] eptr,
                    input logic [3:0] ecnt, input logic eovf);
    drive(name, 1'b1, v, c, d, 1'b0, 3'd0, 4'd0, 64'd0, etop, eptr, ecnt, eovf);
  endtask

  task automatic do_reset(input string name);
    // Push held during reset must have no effect.
    drive(name, 1'b0, 1'b1, 2'b01, 64'hDEAD, 1'b1, 3'd5, 4'd5, 64'hBEEF,
          64'd0, 3'd0, 4'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ctrl = 2'b00; data = '0;
    rec = 1'b0; rec_ptr = '0; rec_cnt = '0; rec_data = '0;

    do_reset("reset");
    op("empty_pop",     1, 2'b10, 64'h0,    64'h0,    3'd0, 4'd0, 0);
    op("push_1000",     1, 2'b01, 64'h1000, 64'h1004, 3'd1, 4'd1, 0);
    op("push_2000",     1, 2'b01, 64'h2000, 64'h2004, 3'd2, 4'd2, 0);
    op("ctrl_none",     1, 2'b00, 64'h5000, 64'h2004, 3'd2, 4'd2, 0);
    op("pop",           1, 2'b10, 64'h0,    64'h1004, 3'd1, 4'd1, 0);
    op("poppush",       1, 2'b11, 64'h3000, 64'h3004, 3'd1, 4'd1, 0);
    op("pop_to_empty",  1, 2'b10, 64'h0,    64'h0,    3'd0, 4'd0, 0);
    op("poppush_empty", 1, 2'b11, 64'h3000, 64'h3004, 3'd1, 4'd1, 0);

    do_reset("reset_ovf");
    op("ovf_push1", 1, 2'b01, 64'h100, 64'h104, 3'd1, 4'd1, 0);
    op("ovf_push2", 1, 2'b01, 64'h200, 64'h204, 3'd2, 4'd2, 0);
    op("ovf_push3", 1, 2'b01, 64'h300, 64'h304, 3'd3, 4'd3, 0);
    op("ovf_push4", 1, 2'b01, 64'h400, 64'h404, 3'd4, 4'd4, 0);
    op("ovf_push5", 1, 2'b01, 64'h500, 64'h504, 3'd5, 4'd5, 0);
    op("ovf_push6", 1, 2'b01, 64'h600, 64'h604, 3'd6, 4'd6, 0);
    op("ovf_push7", 1, 2'b01, 64'h700, 64'h704, 3'd7, 4'd7, 0);
    op("ovf_push8", 1, 2'b01, 64'h800, 64'h804, 3'd0, 4'd8, 0);
    op("ovf_push9", 1, 2'b01, 64'h900, 64'h904, 3'd1, 4'd8, 1);
    op("ovf_pop1",  1, 2'b10, 64'h0,   64'h804, 3'd0, 4'd7, 0);
    op("ovf_pop2",  1, 2'b10, 64'h0,   64'h704, 3'd7, 4'd6, 0);
    op("ovf_pop3",  1, 2'b10, 64'h0,   64'h604, 3'd6, 4'd5, 0);
    op("ovf_pop4",  1, 2'b10, 64'h0,   64'h504, 3'd5, 4'd4, 0);
    op("ovf_pop5",  1, 2'b10, 64'h0,   64'h404, 3'd4, 4'd3, 0);
    op("ovf_pop6",  1, 2'b10, 64'h0,   64'h304, 3'd3, 4'd2, 0);
    op("ovf_pop7",  1, 2'b10, 64'h0,   64'h204, 3'd2, 4'd1, 0);
    op("ovf_pop8",  1, 2'b10, 64'h0,   64'h0,   3'd1, 4'd0, 0);
    op("underflow", 1, 2'b10, 64'h0,   64'h0,   3'd1, 4'd0, 0);

    do_reset("reset_rec");
    op("rec_push1", 1, 2'b01, 64'h10, 64'h14, 3'd1, 4'd1, 0);
    op("rec_push2", 1, 2'b01, 64'h20, 64'h24, 3'd2, 4'd2, 0);
    op("rec_push3", 1, 2'b01, 64'h30, 64'h34, 3'd3, 4'd3, 0);
    drive("recover_prio", 1'b1, 1'b1, 2'b01, 64'h9990, 1'b1, 3'd1, 4'd1, 64'hABC0,
          64'hABC0, 3'd1, 4'd1, 1'b0);
    op("rec_push4", 1, 2'b01, 64'h40, 64'h44, 3'd2, 4'd2, 0);
    drive("recover_clamp", 1'b1, 1'b0, 2'b00, 64'h0, 1'b1, 3'd5, 4'd15, 64'h55,
          64'h55, 3'd5, 4'd8, 1'b0);
    op("clamp_pop1", 1, 2'b10, 64'h0, 64'h0,  3'd4, 4'd7, 0);
    op("clamp_pop2", 1, 2'b10, 64'h0, 64'h34, 3'd3, 4'd6, 0);
    op("valid_gate", 0, 2'b01, 64'h7777, 64'h34, 3'd3, 4'd6, 0);
    do_reset("reset_midstream");
    op("post_reset_push", 1, 2'b01, 64'h40, 64'h44, 3'd1, 4'd1, 0);

    @(negedge clk);
    valid = 1'b0; ctrl = 2'b00;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
